// File: rtl/wb_router_pkg.sv
// Shared types for the Wishbone address-decode router.
// Holds the router FSM encoding and the error-counter width.
// Imported by the router top and its address matcher.
package wb_router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    RESP
  } router_state_e;

  localparam int ERR_COUNT_WIDTH = 16;

endpackage

// File: rtl/wb_if.sv
// Single-beat Wishbone classic bus bundle.
// master drives the request fields; slave returns dat_r and ack.
// No storage; purely a signal grouping.
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW/8-1:0] sel;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          ack;

  modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack);

endinterface

// File: rtl/wb_addr_match.sv
// Priority address decoder: finds the lowest-index slave whose base/mask matches.
// Latency: purely combinational.
// No flow control; the caller decides when the result is used.
module wb_addr_match
  import wb_router_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int AW       = 32,
  localparam int IDX_W   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
  input  logic [AW-1:0]          adr,
  input  logic [N_SLAVES*AW-1:0] slave_base,
  input  logic [N_SLAVES*AW-1:0] slave_mask,
  output logic                   hit,
  output logic [IDX_W-1:0]       idx
);

  // Scan from the top index down so the lowest matching index is written last and wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((adr & slave_mask[i*AW +: AW]) == slave_base[i*AW +: AW]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_addr_decode_router.sv
// Wishbone 1-to-N router: decodes each upstream access and forwards it to one slave.
// Latency: slave strobe one cycle after the upstream strobe is sampled; ack returns two cycles after the slave ack.
// Misses and slave timeouts are closed with an error-data ack, so the upstream bridge never hangs.
module wb_addr_decode_router
  import wb_router_pkg::*;
#(
  parameter int N_SLAVES         = 4,
  parameter int WB_ADDRESS_WIDTH = 32,
  parameter int WB_DATA_WIDTH    = 32,
  parameter logic [N_SLAVES*WB_ADDRESS_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [N_SLAVES*WB_ADDRESS_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES   = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                         axi_clk,
  input  logic                         rstn,
  wb_if.slave                          wb_i,
  wb_if.master                         wb_o [N_SLAVES],
  output logic                         err_o,
  output logic [WB_ADDRESS_WIDTH-1:0]  err_addr_o,
  output logic [ERR_COUNT_WIDTH-1:0]   err_count_o
);

  localparam int AW    = WB_ADDRESS_WIDTH;
  localparam int DW    = WB_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [DW-1:0]    ERR_RDATA = DW'(ERR_DATA);
  localparam logic [CNT_W-1:0] TMO_VAL   = CNT_W'(TIMEOUT_CYCLES);

  // Request capture and transaction bookkeeping
  router_state_e          state_q, state_d;
  logic [AW-1:0]          adr_q, adr_d;
  logic                   we_q, we_d;
  logic [SW-1:0]          sel_q, sel_d;
  logic [DW-1:0]          dat_w_q, dat_w_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   err_flag_q, err_flag_d;
  logic [DW-1:0]          capt_q, capt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cnt_inc;

  // Upstream response and error reporting
  logic                   ack_q, ack_d;
  logic [DW-1:0]          dat_r_q, dat_r_d;
  logic                   err_q, err_d;
  logic [AW-1:0]          err_addr_q, err_addr_d;
  logic [ERR_COUNT_WIDTH-1:0] err_count_q, err_count_d;

  // Per-port registered request outputs
  logic [N_SLAVES-1:0]    port_cyc_q, port_cyc_d;
  logic [N_SLAVES-1:0]    port_we_q, port_we_d;
  logic [AW-1:0]          port_adr_q [N_SLAVES];
  logic [AW-1:0]          port_adr_d [N_SLAVES];
  logic [SW-1:0]          port_sel_q [N_SLAVES];
  logic [SW-1:0]          port_sel_d [N_SLAVES];
  logic [DW-1:0]          port_dat_w_q [N_SLAVES];
  logic [DW-1:0]          port_dat_w_d [N_SLAVES];

  // Slave responses gathered into plain arrays so they can be indexed by idx_q
  logic [N_SLAVES-1:0]    slv_ack;
  logic [DW-1:0]          slv_dat_r [N_SLAVES];

  logic                   match_hit;
  logic [IDX_W-1:0]       match_idx;

  wb_addr_match #(
    .N_SLAVES (N_SLAVES),
    .AW       (AW)
  ) u_match (
    .adr        (wb_i.adr),
    .slave_base (SLAVE_BASE),
    .slave_mask (SLAVE_MASK),
    .hit        (match_hit),
    .idx        (match_idx)
  );

  for (genvar g = 0; g < N_SLAVES; g++) begin : g_port
    assign slv_ack[g]     = wb_o[g].ack;
    assign slv_dat_r[g]   = wb_o[g].dat_r;
    assign wb_o[g].cyc    = port_cyc_q[g];
    assign wb_o[g].stb    = port_cyc_q[g];
    assign wb_o[g].we     = port_we_q[g];
    assign wb_o[g].adr    = port_adr_q[g];
    assign wb_o[g].sel    = port_sel_q[g];
    assign wb_o[g].dat_w  = port_dat_w_q[g];
  end

  assign wb_i.ack    = ack_q;
  assign wb_i.dat_r  = dat_r_q;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;
  assign err_count_o = err_count_q;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state logic: accept and decode in IDLE, wait for ack/timeout/abort in FWD, answer in RESP.
  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    we_d        = we_q;
    sel_d       = sel_q;
    dat_w_d     = dat_w_q;
    idx_d       = idx_q;
    err_flag_d  = err_flag_q;
    capt_d      = capt_q;
    cnt_d       = cnt_q;
    ack_d       = 1'b0;
    dat_r_d     = dat_r_q;
    err_d       = 1'b0;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;

    case (state_q)
      IDLE: begin
        // ack_q high means the master is still holding the strobe of the access just answered.
        if (wb_i.cyc && wb_i.stb && !ack_q) begin
          adr_d   = wb_i.adr;
          we_d    = wb_i.we;
          sel_d   = wb_i.sel;
          dat_w_d = wb_i.dat_w;
          idx_d   = match_idx;
          if (match_hit) begin
            state_d    = FWD;
            cnt_d      = '0;
            err_flag_d = 1'b0;
          end else begin
            state_d    = RESP;
            err_flag_d = 1'b1;
            capt_d     = ERR_RDATA;
          end
        end
      end

      FWD: begin
        if (!wb_i.cyc) begin
          state_d = IDLE;
        end else if (slv_ack[idx_q]) begin
          // A late ack in the timeout cycle still counts as a normal completion.
          state_d    = RESP;
          err_flag_d = 1'b0;
          capt_d     = slv_dat_r[idx_q];
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO_VAL) begin
            state_d    = RESP;
            err_flag_d = 1'b1;
            capt_d     = ERR_RDATA;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
        ack_d   = 1'b1;
        dat_r_d = capt_q;
        if (err_flag_q) begin
          err_d      = 1'b1;
          err_addr_d = adr_q;
          if (err_count_q != '1) begin
            err_count_d = err_count_q + ERR_COUNT_WIDTH'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Only the selected port carries a request, and only while the next state is FWD.
  always_comb begin
    for (int i = 0; i < N_SLAVES; i++) begin
      port_cyc_d[i]   = (state_d == FWD) && (int'(idx_d) == i);
      port_we_d[i]    = port_cyc_d[i] ? we_d : 1'b0;
      port_adr_d[i]   = port_cyc_d[i] ? adr_d : '0;
      port_sel_d[i]   = port_cyc_d[i] ? sel_d : '0;
      port_dat_w_d[i] = port_cyc_d[i] ? dat_w_d : '0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge axi_clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      adr_q        <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      dat_w_q      <= '0;
      idx_q        <= '0;
      err_flag_q   <= 1'b0;
      capt_q       <= '0;
      cnt_q        <= '0;
      ack_q        <= 1'b0;
      dat_r_q      <= '0;
      err_q        <= 1'b0;
      err_addr_q   <= '0;
      err_count_q  <= '0;
      port_cyc_q   <= '0;
      port_we_q    <= '0;
      port_adr_q   <= '{default: '0};
      port_sel_q   <= '{default: '0};
      port_dat_w_q <= '{default: '0};
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      dat_w_q      <= dat_w_d;
      idx_q        <= idx_d;
      err_flag_q   <= err_flag_d;
      capt_q       <= capt_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      dat_r_q      <= dat_r_d;
      err_q        <= err_d;
      err_addr_q   <= err_addr_d;
      err_count_q  <= err_count_d;
      port_cyc_q   <= port_cyc_d;
      port_we_q    <= port_we_d;
      port_adr_q   <= port_adr_d;
      port_sel_q   <= port_sel_d;
      port_dat_w_q <= port_dat_w_d;
    end
  end

endmodule

// File: tb/tb_wb_addr_decode_router.sv
// Self-checking bench for wb_addr_decode_router with behavioural slaves.
// Expected latency/data/strobe counts come from the address map and slave delays.
// Directed scenarios followed by randomized accesses.
module tb_wb_addr_decode_router;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam logic [N*AW-1:0] BASE = {32'h3000_0000, 32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [N*AW-1:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000};

  logic [31:0] m_base [N] = '{32'h0000_0000, 32'h1000_0000, 32'h0000_0000, 32'h3000_0000};
  logic [31:0] m_mask [N] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000};

  logic axi_clk = 1'b0;
  logic rstn    = 1'b0;
  always #5 axi_clk = ~axi_clk;

  wb_if #(.AW(AW), .DW(DW)) up_if ();
  wb_if #(.AW(AW), .DW(DW)) slv_if [N] ();

  logic        err_o;
  logic [31:0] err_addr_o;
  logic [15:0] err_count_o;

  wb_addr_decode_router #(
    .N_SLAVES         (N),
    .WB_ADDRESS_WIDTH (AW),
    .WB_DATA_WIDTH    (DW),
    .SLAVE_BASE       (BASE),
    .SLAVE_MASK       (MASK),
    .TIMEOUT_CYCLES   (TMO),
    .ERR_DATA         (32'hDEADBEEF)
  ) dut (
    .axi_clk     (axi_clk),
    .rstn        (rstn),
    .wb_i        (up_if),
    .wb_o        (slv_if),
    .err_o       (err_o),
    .err_addr_o  (err_addr_o),
    .err_count_o (err_count_o)
  );

  // Slave-side views
  logic [N-1:0]  s_cyc, s_stb, s_we;
  logic [N-1:0]  s_ack = '0;
  logic [31:0]   s_adr  [N];
  logic [3:0]    s_sel  [N];
  logic [31:0]   s_datw [N];
  logic [31:0]   s_datr [N] = '{default: 32'h0};
  int            s_delay [N] = '{default: 0};
  logic [31:0]   s_data  [N] = '{default: 32'h0};
  int            s_cnt   [N] = '{default: 0};

  for (genvar g = 0; g < N; g++) begin : g_slv
    assign s_cyc[g]         = slv_if[g].cyc;
    assign s_stb[g]         = slv_if[g].stb;
    assign s_we[g]          = slv_if[g].we;
    assign s_adr[g]         = slv_if[g].adr;
    assign s_sel[g]         = slv_if[g].sel;
    assign s_datw[g]        = slv_if[g].dat_w;
    assign slv_if[g].ack    = s_ack[g];
    assign slv_if[g].dat_r  = s_datr[g];
  end

  // Behavioural slave: acks on the s_delay-th cycle its strobe is seen; delay 0 never acks.
  always @(negedge axi_clk) begin
    for (int i = 0; i < N; i++) begin
      if (s_cyc[i] && s_stb[i]) begin
        s_cnt[i]  = s_cnt[i] + 1;
        s_ack[i]  = (s_cnt[i] == s_delay[i]);
        s_datr[i] = s_ack[i] ? s_data[i] : 32'h0;
      end else begin
        s_cnt[i]  = 0;
        s_ack[i]  = 1'b0;
        s_datr[i] = 32'h0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  // Error-reporting model
  logic [15:0] m_err_cnt  = 16'h0;
  logic [31:0] m_err_addr = 32'h0;

  // Results of the most recent access
  int          r_lat, r_errp, r_viol, r_xack;
  int          r_stb [N];
  logic [31:0] r_rd;

  function automatic int exp_slave(input logic [31:0] a);
    for (int i = 0; i < N; i++) begin
      if ((a & m_mask[i]) == m_base[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_err(input logic [31:0] a);
    if (m_err_cnt != 16'hFFFF) m_err_cnt = m_err_cnt + 16'h1;
    m_err_addr = a;
  endfunction

  task automatic access(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] wd);
    bit done;
    @(negedge axi_clk);
    up_if.cyc = 1'b1; up_if.stb = 1'b1; up_if.we = w;
    up_if.adr = a; up_if.sel = s; up_if.dat_w = wd;
    r_lat = 0; r_errp = 0; r_viol = 0; r_xack = 0; r_rd = 32'h0; done = 1'b0;
    for (int i = 0; i < N; i++) r_stb[i] = 0;
    while (!done && r_lat < 60) begin
      @(negedge axi_clk);
      r_lat++;
      for (int i = 0; i < N; i++) begin
        if (s_stb[i]) begin
          r_stb[i]++;
          if (!s_cyc[i] || s_we[i] !== w || s_adr[i] !== a || s_sel[i] !== s || s_datw[i] !== wd) r_viol++;
        end else if (s_cyc[i] || s_we[i] || s_adr[i] !== 32'h0 || s_datw[i] !== 32'h0) begin
          r_viol++;
        end
      end
      if (err_o) r_errp++;
      if (up_if.ack) begin
        done = 1'b1;
        r_rd = up_if.dat_r;
      end
    end
    up_if.cyc = 1'b0; up_if.stb = 1'b0; up_if.we = 1'b0;
    up_if.adr = 32'h0; up_if.sel = 4'h0; up_if.dat_w = 32'h0;
    repeat (2) begin
      @(negedge axi_clk);
      if (up_if.ack) r_xack++;
      if (err_o) r_errp++;
      for (int i = 0; i < N; i++) if (s_stb[i]) r_stb[i]++;
    end
  endtask

  task automatic test_reset();
    int nz;
    rstn = 1'b0;
    repeat (3) @(negedge axi_clk);
    nz = 0;
    for (int i = 0; i < N; i++) if (s_adr[i] !== 32'h0 || s_sel[i] !== 4'h0 || s_datw[i] !== 32'h0) nz++;
    checks++; if (up_if.ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", up_if.ack); end
    checks++; if (up_if.dat_r !== 32'h0) begin errors++; $display("FAIL reset_datr got %h want 0", up_if.dat_r); end
    checks++; if ((s_cyc | s_stb | s_we) !== 4'h0) begin errors++; $display("FAIL reset_ctl got %b/%b/%b want 0", s_cyc, s_stb, s_we); end
    checks++; if (nz !== 0) begin errors++; $display("FAIL reset_fields got %0d nonzero ports want 0", nz); end
    checks++; if ({err_o, err_addr_o, err_count_o} !== 49'h0) begin errors++; $display("FAIL reset_err got %b %h %h want 0", err_o, err_addr_o, err_count_o); end
    rstn = 1'b1;
  endtask

  task automatic test_read_hit();
    s_delay[1] = 3; s_data[1] = 32'hA5A5_0001;
    access(32'h1000_0004, 1'b0, 4'hF, 32'h0);
    checks++; if (r_lat !== 5) begin errors++; $display("FAIL rd_lat got %0d want 5", r_lat); end
    checks++; if (r_rd !== 32'hA5A5_0001) begin errors++; $display("FAIL rd_data got %h want a5a50001", r_rd); end
    checks++; if (r_stb[1] !== 3 || r_stb[0] + r_stb[2] + r_stb[3] !== 0) begin errors++; $display("FAIL rd_stb got %0d,%0d,%0d,%0d want 0,3,0,0", r_stb[0], r_stb[1], r_stb[2], r_stb[3]); end
    checks++; if (r_viol !== 0 || r_errp !== 0 || r_xack !== 0) begin errors++; $display("FAIL rd_clean got viol %0d err %0d xack %0d want 0", r_viol, r_errp, r_xack); end
  endtask

  task automatic test_write_hit();
    s_delay[0] = 2; s_data[0] = 32'h0000_00AA;
    access(32'h0000_0010, 1'b1, 4'hF, 32'h1234_5678);
    checks++; if (r_lat !== 4) begin errors++; $display("FAIL wr_lat got %0d want 4", r_lat); end
    checks++; if (r_stb[0] !== 2 || r_stb[1] + r_stb[2] + r_stb[3] !== 0) begin errors++; $display("FAIL wr_stb got %0d,%0d,%0d,%0d want 2,0,0,0", r_stb[0], r_stb[1], r_stb[2], r_stb[3]); end
    checks++; if (r_viol !== 0) begin errors++; $display("FAIL wr_fields got %0d bad cycles want 0", r_viol); end
  endtask

  task automatic test_miss();
    access(32'h2000_0000, 1'b0, 4'hF, 32'h0);
    model_err(32'h2000_0000);
    checks++; if (r_lat !== 2) begin errors++; $display("FAIL miss_lat got %0d want 2", r_lat); end
    checks++; if (r_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_data got %h want deadbeef", r_rd); end
    checks++; if (r_stb[0] + r_stb[1] + r_stb[2] + r_stb[3] !== 0) begin errors++; $display("FAIL miss_stb got strobes want none"); end
    checks++; if (r_errp !== 1) begin errors++; $display("FAIL miss_errpulse got %0d want 1", r_errp); end
    checks++; if (err_addr_o !== m_err_addr || err_count_o !== m_err_cnt) begin errors++; $display("FAIL miss_errregs got %h/%0d want %h/%0d", err_addr_o, err_count_o, m_err_addr, m_err_cnt); end
    checks++; if (up_if.dat_r !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_hold got %h want deadbeef", up_if.dat_r); end
  endtask

  task automatic test_timeout();
    s_delay[0] = 0;
    access(32'h0000_0020, 1'b0, 4'hF, 32'h0);
    model_err(32'h0000_0020);
    checks++; if (r_lat !== TMO + 2 || r_stb[0] !== TMO) begin errors++; $display("FAIL tmo_timing got lat %0d stb %0d want %0d/%0d", r_lat, r_stb[0], TMO + 2, TMO); end
    checks++; if (r_rd !== 32'hDEADBEEF || r_errp !== 1) begin errors++; $display("FAIL tmo_err got %h/%0d want deadbeef/1", r_rd, r_errp); end
    checks++; if (err_count_o !== m_err_cnt || err_addr_o !== m_err_addr) begin errors++; $display("FAIL tmo_errregs got %h/%0d want %h/%0d", err_addr_o, err_count_o, m_err_addr, m_err_cnt); end
    s_delay[0] = TMO; s_data[0] = 32'h0BAD_F00D;
    access(32'h0000_0024, 1'b0, 4'hF, 32'h0);
    checks++; if (r_lat !== TMO + 2 || r_stb[0] !== TMO) begin errors++; $display("FAIL tmo_edge_timing got lat %0d stb %0d want %0d/%0d", r_lat, r_stb[0], TMO + 2, TMO); end
    checks++; if (r_rd !== 32'h0BAD_F00D || r_errp !== 0 || err_count_o !== m_err_cnt) begin errors++; $display("FAIL tmo_edge_ok got %h/%0d/%0d want 0badf00d/0/%0d", r_rd, r_errp, err_count_o, m_err_cnt); end
  endtask

  task automatic test_overlap();
    s_delay[0] = 1; s_data[0] = 32'h1111_0000;
    s_delay[2] = 1; s_data[2] = 32'h2222_0000;
    access(32'h0000_0000, 1'b0, 4'hF, 32'h0);
    checks++; if (r_stb[0] !== 1 || r_stb[2] !== 0 || r_rd !== 32'h1111_0000) begin errors++; $display("FAIL overlap_low got stb0 %0d stb2 %0d data %h want 1/0/11110000", r_stb[0], r_stb[2], r_rd); end
    access(32'h0001_0000, 1'b0, 4'hF, 32'h0);
    checks++; if (r_stb[2] !== 1 || r_stb[0] !== 0 || r_rd !== 32'h2222_0000) begin errors++; $display("FAIL overlap_fall got stb0 %0d stb2 %0d data %h want 0/1/22220000", r_stb[0], r_stb[2], r_rd); end
  endtask

  task automatic test_abort();
    int n_ack, n_err;
    s_delay[1] = 0;
    @(negedge axi_clk);
    up_if.cyc = 1'b1; up_if.stb = 1'b1; up_if.we = 1'b0; up_if.adr = 32'h1000_0008; up_if.sel = 4'hF;
    repeat (3) @(negedge axi_clk);
    checks++; if (s_stb[1] !== 1'b1) begin errors++; $display("FAIL abort_fwd got %b want 1", s_stb[1]); end
    up_if.cyc = 1'b0; up_if.stb = 1'b0; up_if.adr = 32'h0; up_if.sel = 4'h0;
    @(negedge axi_clk);
    checks++; if (s_stb !== 4'h0) begin errors++; $display("FAIL abort_drop got %b want 0000", s_stb); end
    n_ack = 0; n_err = 0;
    repeat (12) begin
      @(negedge axi_clk);
      if (up_if.ack) n_ack++;
      if (err_o) n_err++;
    end
    checks++; if (n_ack !== 0 || n_err !== 0 || err_count_o !== m_err_cnt) begin errors++; $display("FAIL abort_quiet got ack %0d err %0d cnt %0d want 0/0/%0d", n_ack, n_err, err_count_o, m_err_cnt); end
  endtask

  task automatic test_reset_mid();
    int n_ack;
    s_delay[0] = 0;
    @(negedge axi_clk);
    up_if.cyc = 1'b1; up_if.stb = 1'b1; up_if.we = 1'b1; up_if.adr = 32'h0000_0040; up_if.sel = 4'h3; up_if.dat_w = 32'hCAFE_0001;
    repeat (3) @(negedge axi_clk);
    checks++; if (s_stb[0] !== 1'b1) begin errors++; $display("FAIL rstmid_fwd got %b want 1", s_stb[0]); end
    rstn = 1'b0;
    @(negedge axi_clk);
    checks++; if (s_stb !== 4'h0 || s_cyc !== 4'h0 || up_if.ack !== 1'b0) begin errors++; $display("FAIL rstmid_drop got stb %b cyc %b ack %b want 0", s_stb, s_cyc, up_if.ack); end
    up_if.cyc = 1'b0; up_if.stb = 1'b0; up_if.we = 1'b0; up_if.adr = 32'h0; up_if.sel = 4'h0; up_if.dat_w = 32'h0;
    rstn = 1'b1;
    m_err_cnt = 16'h0; m_err_addr = 32'h0;
    n_ack = 0;
    repeat (4) begin
      @(negedge axi_clk);
      if (up_if.ack) n_ack++;
    end
    checks++; if (n_ack !== 0 || err_count_o !== 16'h0) begin errors++; $display("FAIL rstmid_noack got ack %0d cnt %0d want 0/0", n_ack, err_count_o); end
    s_delay[0] = 2; s_data[0] = 32'h5555_AAAA;
    access(32'h0000_0040, 1'b0, 4'hF, 32'h0);
    checks++; if (r_lat !== 4 || r_rd !== 32'h5555_AAAA || r_errp !== 0) begin errors++; $display("FAIL rstmid_after got lat %0d data %h err %0d want 4/5555aaaa/0", r_lat, r_rd, r_errp); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, exp_rd;
    logic [3:0]  sl;
    logic        w;
    int          es, dl, exp_lat, exp_stb, tot;
    bit          miss, tmo;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        s_delay[i] = $urandom_range(0, 10);
        s_data[i]  = $urandom;
      end
      case ($urandom_range(0, 4))
        0:       a = {16'h0000, 16'($urandom)};
        1:       a = {16'h1000, 16'($urandom)};
        2:       a = {4'h0, 28'($urandom)};
        3:       a = {4'h3, 28'($urandom)};
        default: a = $urandom;
      endcase
      w  = 1'($urandom);
      sl = 4'($urandom_range(1, 15));
      wd = $urandom;
      es      = exp_slave(a);
      miss    = (es < 0);
      dl      = miss ? 0 : s_delay[es];
      tmo     = !miss && (dl == 0 || dl > TMO);
      exp_lat = miss ? 2 : (tmo ? TMO + 2 : dl + 2);
      exp_stb = miss ? 0 : (tmo ? TMO : dl);
      exp_rd  = (miss || tmo) ? 32'hDEADBEEF : s_data[es];
      access(a, w, sl, wd);
      if (miss || tmo) model_err(a);
      tot = 0;
      for (int i = 0; i < N; i++) tot += r_stb[i];
      checks++; if (r_lat !== exp_lat) begin errors++; $display("FAIL rand_lat it=%0d adr=%h got %0d want %0d", it, a, r_lat, exp_lat); end
      checks++; if (r_rd !== exp_rd) begin errors++; $display("FAIL rand_data it=%0d adr=%h got %h want %h", it, a, r_rd, exp_rd); end
      checks++; if (tot !== exp_stb || (!miss && r_stb[es] !== exp_stb)) begin errors++; $display("FAIL rand_stb it=%0d adr=%h got total %0d want %0d on slave %0d", it, a, tot, exp_stb, es); end
      checks++; if (r_errp !== int'(miss || tmo) || r_viol !== 0 || r_xack !== 0) begin errors++; $display("FAIL rand_misc it=%0d got err %0d viol %0d xack %0d want %0d/0/0", it, r_errp, r_viol, r_xack, int'(miss || tmo)); end
      checks++; if (err_count_o !== m_err_cnt || err_addr_o !== m_err_addr) begin errors++; $display("FAIL rand_errregs it=%0d got %h/%0d want %h/%0d", it, err_addr_o, err_count_o, m_err_addr, m_err_cnt); end
    end
  endtask

  initial begin
    up_if.cyc = 1'b0; up_if.stb = 1'b0; up_if.we = 1'b0;
    up_if.adr = 32'h0; up_if.sel = 4'h0; up_if.dat_w = 32'h0;
    test_reset();
    test_read_hit();
    test_write_hit();
    test_miss();
    test_timeout();
    test_overlap();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
